// File: rtl/regfile_scoreboard.sv
// Register file with a per-register busy scoreboard, pending counter and flush.
// Optional write-to-read forwarding when REGFILE_BYPASS_EN is defined.
module regfile_scoreboard #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [ADDR_WIDTH-1:0] raddr1,
    input  logic [ADDR_WIDTH-1:0] raddr2,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic [DATA_WIDTH-1:0] rdata2,
    output logic                  rbusy1,
    output logic                  rbusy2,
    input  logic                  wen,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  iss_valid,
    input  logic [ADDR_WIDTH-1:0] iss_waddr,
    input  logic                  flush,
    output logic [ADDR_WIDTH:0]   busy_cnt
);

    localparam int unsigned NREG = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] CNT_ONE = 1;

    logic [DATA_WIDTH-1:0] regs [NREG];
    logic [NREG-1:0]       busy;
    logic [NREG-1:0]       busy_n;
    logic [ADDR_WIDTH:0]   cnt;
    logic [ADDR_WIDTH:0]   cnt_n;
    logic                  w_ok;
    logic                  i_ok;
    logic                  cnt_inc;
    logic                  cnt_dec;

    // Zero-register accesses and flushed issues are squashed before touching state.
    always_comb begin
        w_ok = wen && !((ZERO_REG != 0) && (waddr == '0));
        i_ok = iss_valid && !flush && !((ZERO_REG != 0) && (iss_waddr == '0));
    end

    always_comb begin
        busy_n  = busy;
        cnt_n   = cnt;
        cnt_inc = i_ok && !busy[iss_waddr];
        cnt_dec = w_ok && busy[waddr] && !(i_ok && (iss_waddr == waddr));
        if (flush) begin
            busy_n = '0;
            cnt_n  = '0;
        end else begin
            if (w_ok) busy_n[waddr] = 1'b0;
            if (i_ok) busy_n[iss_waddr] = 1'b1;
            if (cnt_inc && !cnt_dec) cnt_n = cnt + CNT_ONE;
            else if (cnt_dec && !cnt_inc) cnt_n = cnt - CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            regs <= '{default: '0};
            busy <= '0;
            cnt  <= '0;
        end else begin
            if (w_ok) regs[waddr] <= wdata;
            busy <= busy_n;
            cnt  <= cnt_n;
        end
    end

    assign busy_cnt = cnt;

    always_comb begin
        rdata1 = regs[raddr1];
        rdata2 = regs[raddr2];
        rbusy1 = busy[raddr1];
        rbusy2 = busy[raddr2];
`ifdef REGFILE_BYPASS_EN
        // Forwarding is gated by resetn so reads stay zero while reset is held.
        if (resetn && w_ok && (waddr == raddr1)) begin
            rdata1 = wdata;
            rbusy1 = 1'b0;
        end
        if (resetn && w_ok && (waddr == raddr2)) begin
            rdata2 = wdata;
            rbusy2 = 1'b0;
        end
        if (resetn && i_ok && (iss_waddr == raddr1)) rbusy1 = 1'b1;
        if (resetn && i_ok && (iss_waddr == raddr2)) rbusy2 = 1'b1;
`endif
        if ((ZERO_REG != 0) && (raddr1 == '0)) begin
            rdata1 = '0;
            rbusy1 = 1'b0;
        end
        if ((ZERO_REG != 0) && (raddr2 == '0)) begin
            rdata2 = '0;
            rbusy2 = 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed scoreboard bench for regfile_scoreboard (default parameters).
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        resetn;
    logic [4:0]  raddr1, raddr2, waddr, iss_waddr;
    logic [31:0] rdata1, rdata2, wdata;
    logic        rbusy1, rbusy2, wen, iss_valid, flush;
    logic [5:0]  busy_cnt;

    typedef struct {
        int          kind;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    regfile_scoreboard #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1)) dut (
        .clk(clk), .resetn(resetn),
        .raddr1(raddr1), .raddr2(raddr2),
        .rdata1(rdata1), .rdata2(rdata2),
        .rbusy1(rbusy1), .rbusy2(rbusy2),
        .wen(wen), .waddr(waddr), .wdata(wdata),
        .iss_valid(iss_valid), .iss_waddr(iss_waddr),
        .flush(flush), .busy_cnt(busy_cnt)
    );

    always #5 clk = ~clk;

    localparam int RD1 = 0, RB1 = 1, RD2 = 2, RB2 = 3, CNT = 4;

    function automatic logic [31:0] observe(input int kind);
        case (kind)
            RD1:     return rdata1;
            RB1:     return 32'(rbusy1);
            RD2:     return rdata2;
            RB2:     return 32'(rbusy2);
            default: return 32'(busy_cnt);
        endcase
    endfunction

    function automatic string kname(input int kind);
        case (kind)
            RD1:     return "rdata1";
            RB1:     return "rbusy1";
            RD2:     return "rdata2";
            RB2:     return "rbusy2";
            default: return "busy_cnt";
        endcase
    endfunction

    task automatic ex(input int kind, input logic [31:0] val);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string step);
        exp_t        e;
        logic [31:0] obs;
        #1;
        while (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            obs = observe(e.kind);
            total++;
            assert (obs === e.val) else begin
                bad++;
                $error("FAIL %s/%s: observed=%h expected=%h", step, kname(e.kind), obs, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                         input logic iv, input logic [4:0] ia, input logic fl);
        wen = w; waddr = wa; wdata = wd;
        iss_valid = iv; iss_waddr = ia; flush = fl;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    endtask

    initial begin
        resetn = 1'b0;
        raddr1 = 5'd5;
        raddr2 = 5'd0;
        drive(1'b1, 5'd5, 32'hFFFF_FFFF, 1'b1, 5'd5, 1'b0);
        #3;
        ex(RD1, 32'h0); ex(RB1, 32'h0); ex(CNT, 32'h0);
        chk("reset_hold");
        tick(); tick();
        ex(RD1, 32'h0); ex(RB1, 32'h0); ex(CNT, 32'h0);
        chk("reset_write_ignored");

        resetn = 1'b1;
        idle();
        tick();
        raddr1 = 5'd5; raddr2 = 5'd31;
        ex(RD1, 32'h0); ex(RD2, 32'h0); ex(RB2, 32'h0);
        chk("after_release");

        drive(1'b1, 5'd3, 32'hDEAD_BEEF, 1'b0, 5'd0, 1'b0);
        raddr1 = 5'd3;
        tick(); idle();
        ex(RD1, 32'hDEAD_BEEF);
        chk("write_r3");

        drive(1'b1, 5'd0, 32'h0000_1234, 1'b0, 5'd0, 1'b0);
        raddr1 = 5'd0;
        tick(); idle();
        ex(RD1, 32'h0); ex(RB1, 32'h0); ex(CNT, 32'h0);
        chk("write_r0");

        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b0);
        tick(); idle();
        raddr1 = 5'd7;
        ex(RB1, 32'h1); ex(CNT, 32'h1);
        chk("issue_r7");

        drive(1'b1, 5'd7, 32'h55, 1'b0, 5'd0, 1'b0);
        tick(); idle();
        ex(RB1, 32'h0); ex(CNT, 32'h0); ex(RD1, 32'h55);
        chk("wb_r7");

        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b0);
        tick(); idle();
        raddr1 = 5'd0;
        ex(RB1, 32'h0); ex(CNT, 32'h0);
        chk("issue_r0");

        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0);
        tick();
        drive(1'b1, 5'd9, 32'h99, 1'b1, 5'd9, 1'b0);
        tick(); idle();
        raddr1 = 5'd9;
        ex(RD1, 32'h99); ex(RB1, 32'h1); ex(CNT, 32'h1);
        chk("same_cycle_r9");

        drive(1'b1, 5'd11, 32'h11, 1'b0, 5'd0, 1'b0);
        tick(); idle();
        raddr2 = 5'd11;
        ex(RD2, 32'h11); ex(RB2, 32'h0); ex(CNT, 32'h1);
        chk("write_nonbusy");

        drive(1'b1, 5'd9, 32'h9A, 1'b1, 5'd12, 1'b0);
        tick(); idle();
        raddr1 = 5'd9; raddr2 = 5'd12;
        ex(RD1, 32'h9A); ex(RB1, 32'h0); ex(RB2, 32'h1); ex(CNT, 32'h1);
        chk("diff_addr");

        drive(1'b1, 5'd12, 32'h12, 1'b1, 5'd1, 1'b0);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 1'b0);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0);
        tick(); idle();
        raddr1 = 5'd2; raddr2 = 5'd12;
        ex(RB1, 32'h1); ex(RB2, 32'h0); ex(CNT, 32'h3);
        chk("issue_r1_r3");

        drive(1'b1, 5'd5, 32'h5555, 1'b1, 5'd4, 1'b1);
        tick(); idle();
        raddr1 = 5'd4; raddr2 = 5'd5;
        ex(RB1, 32'h0); ex(RD2, 32'h5555); ex(RB2, 32'h0); ex(CNT, 32'h0);
        chk("flush");
        raddr1 = 5'd2;
        ex(RB1, 32'h0);
        chk("flush_r2");

        drive(1'b1, 5'd10, 32'hA5A5_A5A5, 1'b0, 5'd0, 1'b0);
        raddr2 = 5'd10;
`ifdef REGFILE_BYPASS_EN
        ex(RD2, 32'hA5A5_A5A5);
`else
        ex(RD2, 32'h0);
`endif
        ex(RB2, 32'h0);
        chk("bypass_same_cycle");
        tick(); idle();
        ex(RD2, 32'hA5A5_A5A5);
        chk("bypass_next_cycle");

        drive(1'b1, 5'd10, 32'h77, 1'b1, 5'd10, 1'b0);
`ifdef REGFILE_BYPASS_EN
        ex(RD2, 32'h77); ex(RB2, 32'h1);
`else
        ex(RD2, 32'hA5A5_A5A5); ex(RB2, 32'h0);
`endif
        chk("bypass_with_issue");
        tick(); idle();
        ex(RD2, 32'h77); ex(RB2, 32'h1); ex(CNT, 32'h1);
        chk("after_wb_issue_r10");

        for (int i = 1; i < 32; i++) begin
            drive(1'b0, 5'd0, 32'h0, 1'b1, 5'(i), 1'b0);
            tick();
        end
        ex(CNT, 32'd31);
        chk("all_busy");
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b0);
        tick(); idle();
        ex(CNT, 32'd31);
        chk("reissue_busy_max");

        drive(1'b1, 5'd13, 32'h1313, 1'b1, 5'd14, 1'b0);
        resetn = 1'b0;
        raddr1 = 5'd10; raddr2 = 5'd13;
        ex(RD1, 32'h0); ex(RB1, 32'h0); ex(RD2, 32'h0); ex(RB2, 32'h0); ex(CNT, 32'h0);
        chk("mid_reset");
        tick();
        ex(RD2, 32'h0); ex(CNT, 32'h0);
        chk("mid_reset_edge");

        resetn = 1'b1;
        drive(1'b1, 5'd15, 32'hF0F0, 1'b0, 5'd0, 1'b0);
        raddr1 = 5'd15;
`ifdef REGFILE_BYPASS_EN
        ex(RD1, 32'hF0F0);
`else
        ex(RD1, 32'h0);
`endif
        chk("deassert_cycle");
        tick(); idle();
        ex(RD1, 32'hF0F0); ex(CNT, 32'h0);
        chk("first_edge_write");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised general-purpose register file for the pipelined CPU core.
- Adds a per-register busy scoreboard: issue marks a destination pending, writeback clears it.
- Read ports return both data and pending status so decode can detect RAW hazards and stall.
- Adds reset-to-zero of all registers, a pending-register counter and a global flush on exception.

Parameters:
- DATA_WIDTH, 32, register width in bits.
- ADDR_WIDTH, 5, register address width; NREG = 2**ADDR_WIDTH registers (localparam).
- ZERO_REG, 1, 1 = register 0 hardwired to zero and never busy; 0 = register 0 is ordinary.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- raddr1  in  ADDR_WIDTH  read port 1 address.
- raddr2  in  ADDR_WIDTH  read port 2 address.
- rdata1  out  DATA_WIDTH  read port 1 data.
- rdata2  out  DATA_WIDTH  read port 2 data.
- rbusy1  out  1  register at raddr1 has a pending write.
- rbusy2  out  1  register at raddr2 has a pending write.
- wen  in  1  writeback enable.
- waddr  in  ADDR_WIDTH  writeback address.
- wdata  in  DATA_WIDTH  writeback data.
- iss_valid  in  1  an instruction issues with a destination register.
- iss_waddr  in  ADDR_WIDTH  destination of the issuing instruction.
- flush  in  1  clear all busy bits (exception/redirect).
- busy_cnt  out  ADDR_WIDTH+1  number of currently busy registers.

Behaviour:
- Reset (resetn low, asynchronous): all NREG registers = 0, all busy bits = 0, busy_cnt = 0.
- Outputs during reset: rdata* = 0, rbusy* = 0.
- Reads are combinational from the array and busy vector; zero latency.
- Write: on the rising edge with wen=1, reg[waddr] <= wdata, and busy[waddr] <= 0.
- Writing a non-busy register is legal: data is written, busy stays 0.
- Issue: on the rising edge with iss_valid=1, busy[iss_waddr] <= 1.
- ZERO_REG=1:
  - Writes and issues to address 0 are ignored.
  - Reads of address 0 return 0 with rbusy=0.
- Simultaneous wen and iss_valid to the same address: data is written and busy ends at 1 (the new producer wins).
- Simultaneous wen and iss_valid to different addresses: both take effect.
- Flush:
  - On the rising edge with flush=1, all busy bits go to 0 and busy_cnt goes to 0.
  - An issue in the same cycle is discarded.
  - A wen in the same cycle still writes its data.
- busy_cnt is a registered counter:
  - +1 when an issue sets a previously clear bit.
  - -1 when a write clears a previously set bit that is not re-issued in the same cycle.
  - Net change in one cycle is -1, 0 or +1.
  - Must always equal the popcount of the busy vector; never wraps, max NREG (NREG-1 with ZERO_REG=1).
- Reset asserted mid-operation: state clears immediately regardless of wen, iss_valid or flush.
- A write in the deassertion cycle takes effect only on the first edge with resetn high.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-to-read forwarding.
  - If wen=1 and waddr==raddrN (and not the zero register), rdataN = wdata combinationally in the same cycle.
  - rbusyN = 0 unless iss_valid targets the same address in that cycle.
- Not defined: rdataN and rbusyN show the pre-write array and busy state until the edge; the new value is visible the cycle after the write.

Test Plan:
- Reset then read: resetn low, write attempts to r5 -> rdata1 = 0, rbusy1 = 0, busy_cnt = 0; after release, reading any register returns 0.
- Write/read: wen, waddr=3, wdata=0xDEADBEEF; next cycle raddr1=3 -> rdata1 = 0xDEADBEEF. Write r0 = 0x1234 -> reads 0, busy_cnt unchanged.
- Scoreboard: issue r7 -> rbusy(7) = 1, busy_cnt = 1.
  - Then wen r7 = 0x55 -> rbusy = 0, busy_cnt = 0, rdata = 0x55.
- Same-cycle issue and write r9 (r9 busy beforehand) -> r9 holds wdata, rbusy = 1, busy_cnt unchanged.
- Flush: issue r1, r2, r3 (busy_cnt = 3); flush with issue r4 in the same cycle -> all busy = 0, busy_cnt = 0, r4 not busy.
- Bypass, with REGFILE_BYPASS_EN defined: wen r10 = 0xA5A5A5A5 and raddr2 = 10 in the same cycle -> rdata2 = 0xA5A5A5A5 that cycle.
  - Without the macro: old value that cycle, new value the next cycle.
